// File: rtl/bank_pkg.sv
// Shared definitions for the bank collector/distributor pair: default sizing,
// FSM encoding and the row-to-bank address mapping used on both sides.
package bank_pkg;

  localparam int DEF_CHANNEL_NUMBER    = 3;
  localparam int DEF_CHANNEL_BANDWIDTH = 128;
  localparam int DEF_BANK_DEPTH        = 480;
  localparam int DEPTH_OFFSET          = DEF_BANK_DEPTH / DEF_CHANNEL_NUMBER;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int segment_of(int a, int offset = DEPTH_OFFSET,
                                    int num = DEF_CHANNEL_NUMBER);
    int s;
    s = a / offset;
    if (s > num - 1) s = num - 1;
    return s;
  endfunction

  function automatic int bank_address(int a, int b, int offset = DEPTH_OFFSET,
                                      int depth = DEF_BANK_DEPTH);
    return (a + b * offset) % depth;
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry output buffer with a combinational bypass when empty, so data
// arriving from the banks can be presented in the same cycle it lands.
module skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
  logic             push, pop;

  always_comb begin
    pop   = out_ready && (cnt_q != 2'd0);
    push  = in_valid && !((cnt_q == 2'd0) && out_ready);
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (pop) begin
      e0_d  = e1_q;
      cnt_d = cnt_d - 2'd1;
    end
    if (push) begin
      if (cnt_d == 2'd0) e0_d = in_data;
      else               e1_d = in_data;
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end

  assign out_valid = in_valid || (cnt_q != 2'd0);
  assign out_data  = (cnt_q != 2'd0) ? e0_q : (in_valid ? in_data : '0);
  assign occupancy = cnt_q;

endmodule

// File: rtl/bank_collector.sv
// Streams rows out of rotated banks and de-rotates them into lane order.
// Optional stall counter output is enabled by defining BANK_COLLECTOR_STATS_EN.
module bank_collector
  import bank_pkg::*;
#(
  parameter int CHANNEL_NUMBER    = DEF_CHANNEL_NUMBER,
  parameter int CHANNEL_BANDWIDTH = DEF_CHANNEL_BANDWIDTH,
  parameter int BANK_DEPTH        = DEF_BANK_DEPTH
) (
  input  logic                                        I_clk,
  input  logic                                        I_rst_n,
  input  logic                                        I_start,
  input  logic [$clog2(BANK_DEPTH)-1:0]               I_base_address,
  input  logic [$clog2(BANK_DEPTH+1)-1:0]             I_row_count,
  output logic [CHANNEL_NUMBER-1:0]                   O_bank_rd_en,
  output logic [CHANNEL_NUMBER*$clog2(BANK_DEPTH)-1:0] O_bank_address,
  input  logic [CHANNEL_NUMBER*CHANNEL_BANDWIDTH-1:0] I_bank_data,
  output logic [CHANNEL_NUMBER*CHANNEL_BANDWIDTH-1:0] O_data,
  output logic                                        O_valid,
  input  logic                                        I_ready,
  output logic                                        O_last,
  output logic                                        O_busy,
  output logic                                        O_done
`ifdef BANK_COLLECTOR_STATS_EN
  ,
  output logic [15:0]                                 O_stall_count
`endif
);

  localparam int AW     = $clog2(BANK_DEPTH);
  localparam int CW     = $clog2(BANK_DEPTH + 1);
  localparam int BW     = CHANNEL_BANDWIDTH;
  localparam int DW     = CHANNEL_NUMBER * BW;
  localparam int SW     = (CHANNEL_NUMBER > 1) ? $clog2(CHANNEL_NUMBER) : 1;
  localparam int OFFSET = BANK_DEPTH / CHANNEL_NUMBER;

  state_t          state_q, state_d;
  logic [AW-1:0]   row_q, row_d;
  logic [CW-1:0]   rows_left_q, rows_left_d;
  logic            inflight_q, inflight_d;
  logic            inflight_last_q, inflight_last_d;
  logic [SW-1:0]   inflight_seg_q, inflight_seg_d;
  logic            zero_done_q, zero_done_d;
  logic            issue, credit, accept_last, start_accept;
  logic [DW-1:0]   rot;
  logic [DW:0]     sb_data;
  logic            sb_valid;
  logic [1:0]      occupancy;

  assign credit       = ({1'b0, occupancy} + {2'b00, inflight_q}) < 3'd2;
  assign start_accept = (state_q == IDLE) && I_start;
  assign accept_last  = sb_valid && I_ready && sb_data[DW];

  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    rows_left_d    = rows_left_q;
    zero_done_d    = 1'b0;
    issue          = 1'b0;
    O_bank_address = '0;
    case (state_q)
      IDLE: begin
        if (I_start) begin
          if (I_row_count != '0) begin
            state_d     = READ;
            row_d       = I_base_address;
            rows_left_d = I_row_count;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (credit) begin
          issue       = 1'b1;
          row_d       = (row_q == AW'(BANK_DEPTH - 1)) ? '0 : row_q + AW'(1);
          rows_left_d = rows_left_q - CW'(1);
          if (rows_left_q == CW'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (accept_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Every bank reads its slice of the same row in lockstep.
    for (int b = 0; b < CHANNEL_NUMBER; b++) begin
      if (issue)
        O_bank_address[b*AW +: AW] = AW'(bank_address(int'(row_q), b, OFFSET, BANK_DEPTH));
    end
    O_bank_rd_en    = {CHANNEL_NUMBER{issue}};
    inflight_d      = issue;
    inflight_last_d = issue && (rows_left_q == CW'(1));
    inflight_seg_d  = issue ? SW'(segment_of(int'(row_q), OFFSET, CHANNEL_NUMBER))
                            : inflight_seg_q;
  end

  // Undo the write-side rotation: lane ch comes from bank (ch + segment).
  always_comb begin
    rot = '0;
    for (int ch = 0; ch < CHANNEL_NUMBER; ch++)
      rot[ch*BW +: BW] = I_bank_data[((ch + int'(inflight_seg_q)) % CHANNEL_NUMBER)*BW +: BW];
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q         <= IDLE;
      row_q           <= '0;
      rows_left_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      inflight_seg_q  <= '0;
      zero_done_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      row_q           <= row_d;
      rows_left_q     <= rows_left_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      inflight_seg_q  <= inflight_seg_d;
      zero_done_q     <= zero_done_d;
    end
  end

  skid_buffer #(.WIDTH(DW + 1)) u_skid (
    .clk       (I_clk),
    .rst_n     (I_rst_n),
    .in_valid  (inflight_q),
    .in_data   ({inflight_last_q, rot}),
    .out_ready (I_ready),
    .out_valid (sb_valid),
    .out_data  (sb_data),
    .occupancy (occupancy)
  );

  assign O_valid = sb_valid;
  assign O_data  = sb_data[DW-1:0];
  assign O_last  = sb_valid && sb_data[DW];
  assign O_busy  = (state_q != IDLE);
  assign O_done  = zero_done_q || ((state_q == DRAIN) && accept_last);

`ifdef BANK_COLLECTOR_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_accept)
      stall_d = '0;
    else if (O_valid && !I_ready && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign O_stall_count = stall_q;
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_bank_collector.sv
// Directed bench for bank_collector with a queue-based row model and a bank RAM responder.
module tb_bank_collector;

  localparam int N   = 3;
  localparam int BW  = 128;
  localparam int D   = 480;
  localparam int OFF = D / N;
  localparam int AW  = 9;
  localparam int CW  = 9;
  localparam int DW  = N * BW;

  logic            I_clk = 1'b0;
  logic            I_rst_n, I_start, I_ready;
  logic [AW-1:0]   I_base_address;
  logic [CW-1:0]   I_row_count;
  logic [N-1:0]    O_bank_rd_en;
  logic [N*AW-1:0] O_bank_address;
  logic [DW-1:0]   I_bank_data = '0;
  logic [DW-1:0]   O_data;
  logic            O_valid, O_last, O_busy, O_done;
`ifdef BANK_COLLECTOR_STATS_EN
  logic [15:0]     O_stall_count;
`endif

  always #5 I_clk = ~I_clk;

  bank_collector dut (
    .I_clk          (I_clk),
    .I_rst_n        (I_rst_n),
    .I_start        (I_start),
    .I_base_address (I_base_address),
    .I_row_count    (I_row_count),
    .O_bank_rd_en   (O_bank_rd_en),
    .O_bank_address (O_bank_address),
    .I_bank_data    (I_bank_data),
    .O_data         (O_data),
    .O_valid        (O_valid),
    .I_ready        (I_ready),
    .O_last         (O_last),
    .O_busy         (O_busy),
    .O_done         (O_done)
`ifdef BANK_COLLECTOR_STATS_EN
    ,
    .O_stall_count  (O_stall_count)
`endif
  );

  typedef struct { int a; bit last; } beat_t;

  beat_t exp_beat[$];
  int    exp_rd[$];
  int    rd_log[$];
  int    errors = 0, checks = 0;
  int    beats_acc = 0, lasts_acc = 0, stall_model = 0;
  bit    model_busy = 1'b0, zero_due = 1'b0;

  function automatic logic [BW-1:0] word_of(int b, int a);
    return {32'(b + 1), 32'(a), 32'(a * 7 + b) ^ 32'hC0DE0000, ~32'(a)};
  endfunction

  function automatic logic [DW-1:0] exp_row(int a);
    logic [DW-1:0] r;
    int s, bk;
    r = '0;
    s = a / OFF;
    if (s > N - 1) s = N - 1;
    for (int ch = 0; ch < N; ch++) begin
      bk = (ch + s) % N;
      r[ch*BW +: BW] = word_of(bk, (a + bk * OFF) % D);
    end
    return r;
  endfunction

  // Synchronous bank RAM: data appears the cycle after rd_en.
  always @(posedge I_clk)
    for (int b = 0; b < N; b++)
      if (O_bank_rd_en[b])
        I_bank_data[b*BW +: BW] <= word_of(b, int'(O_bank_address[b*AW +: AW]));

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic monitor();
    beat_t bt;
    int    a;
    bit    last_acc, start_ok;
    forever begin
      @(negedge I_clk);
      if (!I_rst_n) begin
        exp_beat.delete();
        exp_rd.delete();
        model_busy  = 1'b0;
        zero_due    = 1'b0;
        stall_model = 0;
      end else begin
        last_acc = 1'b0;
        if (O_bank_rd_en != '0) begin
          chk("rd_en_all", DW'(O_bank_rd_en), DW'({N{1'b1}}));
          if (exp_rd.size() == 0) fail("unexpected_read", int'(O_bank_address[AW-1:0]), -1);
          else begin
            a = exp_rd.pop_front();
            rd_log.push_back(int'(O_bank_address[AW-1:0]));
            for (int b = 0; b < N; b++)
              chk("bank_addr", DW'(O_bank_address[b*AW +: AW]), DW'((a + b * OFF) % D));
          end
        end
        if (O_valid) begin
          if (exp_beat.size() == 0) fail("unexpected_beat", 1, 0);
          else begin
            bt = exp_beat[0];
            chk("row_data", O_data, exp_row(bt.a));
            chk("row_last", DW'(O_last), DW'(bt.last));
            if (I_ready) begin
              void'(exp_beat.pop_front());
              beats_acc++;
              if (O_last) lasts_acc++;
              last_acc = bt.last;
            end
          end
        end
        chk("done", DW'(O_done), DW'(zero_due || last_acc));
        chk("busy", DW'(O_busy), DW'(model_busy));
`ifdef BANK_COLLECTOR_STATS_EN
        chk("stall_count", DW'(O_stall_count), DW'(stall_model));
`endif
        start_ok = I_start && !model_busy;
        zero_due = start_ok && (I_row_count == '0);
        if (start_ok && (I_row_count != '0)) begin
          for (int k = 0; k < int'(I_row_count); k++) begin
            a = (int'(I_base_address) + k) % D;
            exp_rd.push_back(a);
            exp_beat.push_back('{a, k == int'(I_row_count) - 1});
          end
          model_busy = 1'b1;
        end else if (last_acc) model_busy = 1'b0;
        if (start_ok) stall_model = 0;
        else if (O_valid && !I_ready && stall_model < 65535) stall_model++;
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge I_clk); #1; end
  endtask

  task automatic start_txn(input int base, input int cnt);
    @(posedge I_clk); #1;
    I_start        = 1'b1;
    I_base_address = AW'(base);
    I_row_count    = CW'(cnt);
    @(posedge I_clk); #1;
    I_start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (!model_busy && exp_beat.size() == 0 && !zero_due) begin ok = 1'b1; break; end
      @(posedge I_clk); #1;
    end
    if (!ok) fail("timeout_idle", exp_beat.size(), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ctrl"}, DW'({O_valid, O_last, O_done, O_busy, O_bank_rd_en}), '0);
    chk({tag, "_addr"}, DW'(O_bank_address), '0);
    chk({tag, "_data"}, O_data, '0);
`ifdef BANK_COLLECTOR_STATS_EN
    chk({tag, "_stall"}, DW'(O_stall_count), '0);
`endif
  endtask

  initial begin
    I_rst_n = 1'b0; I_start = 1'b0; I_ready = 1'b1;
    I_base_address = '0; I_row_count = '0;
    fork monitor(); join_none
    cycles(3);
    @(negedge I_clk);
    chk_zero_outputs("reset");
    @(posedge I_clk); #1;
    I_rst_n = 1'b1;
    cycles(2);

    // base 0, one row: straight lane order
    start_txn(0, 1);
    @(negedge I_clk);
    chk("t1_rd_en", DW'(O_bank_rd_en), DW'(3'b111));
    chk("t1_addr", DW'(O_bank_address), DW'({9'd320, 9'd160, 9'd0}));
    chk("t1_valid_c1", DW'(O_valid), '0);
    @(negedge I_clk);
    chk("t1_vld_last_done", DW'({O_valid, O_last, O_done}), DW'(3'b111));
    chk("t1_lanes", O_data, {word_of(2, 320), word_of(1, 160), word_of(0, 0)});
    wait_idle(20);

    // base 200 sits in segment 1
    start_txn(200, 1);
    @(negedge I_clk);
    chk("t2_addr", DW'(O_bank_address), DW'({9'd40, 9'd360, 9'd200}));
    @(negedge I_clk);
    chk("t2_lanes", O_data, {word_of(0, 200), word_of(2, 40), word_of(1, 360)});
    wait_idle(20);

    // wrap around the top of the bank
    rd_log.delete(); beats_acc = 0; lasts_acc = 0;
    start_txn(478, 4);
    wait_idle(50);
    chk("t3_reads", DW'(rd_log.size()), DW'(4));
    if (rd_log.size() == 4) begin
      chk("t3_row0", DW'(rd_log[0]), DW'(478));
      chk("t3_row1", DW'(rd_log[1]), DW'(479));
      chk("t3_row2", DW'(rd_log[2]), DW'(0));
      chk("t3_row3", DW'(rd_log[3]), DW'(1));
    end
    chk("t3_beats", DW'(beats_acc), DW'(4));
    chk("t3_lasts", DW'(lasts_acc), DW'(1));

    // back-pressure 1,0,0,1,0,0...
    beats_acc = 0; lasts_acc = 0;
    start_txn(30, 8);
    for (int k = 0; k < 80 && (model_busy || exp_beat.size() != 0); k++) begin
      I_ready = (k % 3 == 0);
      @(posedge I_clk); #1;
    end
    I_ready = 1'b1;
    wait_idle(20);
    chk("t4_beats", DW'(beats_acc), DW'(8));
    chk("t4_lasts", DW'(lasts_acc), DW'(1));
`ifdef BANK_COLLECTOR_STATS_EN
    chk("t4_stall_seen", DW'(O_stall_count != 16'd0), DW'(1));
`endif

    // zero rows
    start_txn(10, 0);
    @(negedge I_clk);
    chk("t5_done", DW'({O_done, O_busy, O_bank_rd_en}), DW'({1'b1, 1'b0, 3'b000}));
    @(negedge I_clk);
    chk("t5_done_once", DW'(O_done), '0);
    wait_idle(10);

    // start while busy is ignored
    I_ready = 1'b0; beats_acc = 0;
    start_txn(0, 8);
    cycles(4);
    start_txn(100, 2);
    @(negedge I_clk);
    chk("t6_busy", DW'(O_busy), DW'(1));
    cycles(1);
    I_ready = 1'b1;
    wait_idle(60);
    chk("t6_beats", DW'(beats_acc), DW'(8));

    // reset mid-stream
    start_txn(0, 8);
    cycles(2);
    I_rst_n = 1'b0;
    @(negedge I_clk);
    chk_zero_outputs("t7_reset");
    @(negedge I_clk);
    chk("t7_no_done", DW'(O_done), '0);
    @(posedge I_clk); #1;
    I_rst_n = 1'b1;
    beats_acc = 0; lasts_acc = 0;
    start_txn(5, 2);
    wait_idle(30);
    chk("t7_beats", DW'(beats_acc), DW'(2));
    chk("t7_lasts", DW'(lasts_acc), DW'(1));

    cycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
